// File: rtl/egress_pkg.sv
// Shared types and helpers for the multi-class egress priority queue.
// Contents: default payload width, class index type, output FSM state
// encoding and the strict-priority picker (lowest set index wins).
package egress_pkg;

  localparam int unsigned EGRESS_DATA_WIDTH = 32;
  localparam int unsigned MAX_CLASS         = 8;

  typedef logic [2:0] class_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } out_state_e;

  // Lowest set bit of the non-empty mask; 0 when the mask is clear.
  function automatic class_idx_t prio_pick(input logic [MAX_CLASS-1:0] mask);
    class_idx_t idx;
    idx = '0;
    for (int i = MAX_CLASS - 1; i >= 0; i--) begin
      if (mask[i]) idx = class_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/egress_class_ctrl.sv
// Per-class circular FIFO bookkeeping: head/tail pointers, word count and
// push acceptance. A push into a full class is still taken when the same
// cycle pops that class, since the slot being read frees up.
// Ports: clk, reset (async active-low); i_push_req push request for this
// class; i_pop fetch of the head word (only asserted when non-empty);
// o_push_ok push accepted; o_head/o_tail RAM addresses; o_count words held;
// o_nonempty count != 0.
module egress_class_ctrl #(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNTW  = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push_req,
  input  logic            i_pop,
  output logic            o_push_ok,
  output logic [AW-1:0]   o_head,
  output logic [AW-1:0]   o_tail,
  output logic [CNTW-1:0] o_count,
  output logic            o_nonempty
);

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CNTW-1:0] r_count;
  logic            w_full;
  logic            w_push_ok;

  assign w_full    = (r_count == CNTW'(DEPTH));
  assign w_push_ok = i_push_req && (!w_full || i_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + AW'(1);
      if (i_pop)     r_head <= r_head + AW'(1);
      if (w_push_ok && !i_pop)      r_count <= r_count + CNTW'(1);
      else if (!w_push_ok && i_pop) r_count <= r_count - CNTW'(1);
    end
  end

  assign o_push_ok  = w_push_ok;
  assign o_head     = r_head;
  assign o_tail     = r_tail;
  assign o_count    = r_count;
  assign o_nonempty = (r_count != '0);

endmodule

// File: rtl/simple_dual_port_mem.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read (data valid the cycle after i_re). A same-address read and write in
// one cycle returns the previous contents.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr/o_rdata read port.
module simple_dual_port_mem #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned WORDS = 2 ** AW;

  logic [DW-1:0] r_mem [WORDS];
  logic [DW-1:0] r_rdata;

  // Storage array carries no reset; read register samples old contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/egress_prio_queue.sv
// Multi-class egress buffer between crossbar and host interface.
// NUM_CLASS independent circular FIFOs fed by a never-stalled push port;
// a push to a full class (or to an out-of-range class) is dropped and
// counted. Output is a valid/ready stream with strict priority, class 0
// highest, via an IDLE -> FETCH -> HOLD stage (1 word per 2 cycles).
// Optional feature macro: EGRESS_WATERMARK_EN (adds HI_WM parameter and
// registered almost_full[NUM_CLASS] output).
// Ports:
//   clk, reset (async active-low)
//   in_en/in_class/in_data   push from crossbar
//   out_valid/out_ready/out_data/out_class   output stream
//   occupancy  per-class words in RAM (held word excluded), class 0 in LSBs
//   drop_cnt   saturating count of rejected pushes
module egress_prio_queue
  import egress_pkg::*;
#(
  parameter  int unsigned DEPTH      = 1024,
  parameter  int unsigned DATA_WIDTH = EGRESS_DATA_WIDTH,
  parameter  int unsigned NUM_CLASS  = 4,
`ifdef EGRESS_WATERMARK_EN
  parameter  int unsigned HI_WM      = DEPTH - 16,
`endif
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned CNTW       = AW + 1,
  localparam int unsigned CW         = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_en,
  input  logic [CW-1:0]             in_class,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CW-1:0]             out_class,
  output logic [NUM_CLASS*CNTW-1:0] occupancy,
  output logic [31:0]               drop_cnt
`ifdef EGRESS_WATERMARK_EN
  ,
  output logic [NUM_CLASS-1:0]      almost_full
`endif
);

  logic [NUM_CLASS-1:0]  w_push_req;
  logic [NUM_CLASS-1:0]  w_push_ok;
  logic [NUM_CLASS-1:0]  w_pop;
  logic [NUM_CLASS-1:0]  w_nonempty;
  logic [AW-1:0]         w_head  [NUM_CLASS];
  logic [AW-1:0]         w_tail  [NUM_CLASS];
  logic [CNTW-1:0]       w_count [NUM_CLASS];
  logic [DATA_WIDTH-1:0] w_rdata [NUM_CLASS];

  logic                  w_class_ok;
  logic                  w_drop;
  logic [MAX_CLASS-1:0]  w_mask;
  class_idx_t            w_pick_idx;
  logic [CW-1:0]         w_pick;

  out_state_e            r_state;
  out_state_e            w_state_nxt;
  logic                  w_fetch;
  logic                  w_load;
  logic                  w_pop_out;

  logic [CW-1:0]         r_fetch_class;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CW-1:0]         r_out_class;
  logic [31:0]           r_drop_cnt;

  assign w_class_ok = (32'(in_class) < NUM_CLASS);

  // Per-class pointer/count control plus its RAM.
  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_class
    assign w_push_req[c] = in_en && w_class_ok && (in_class == CW'(c));
    assign w_pop[c]      = w_fetch && (w_pick == CW'(c));

    egress_class_ctrl #(
      .DEPTH (DEPTH)
    ) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .i_push_req (w_push_req[c]),
      .i_pop      (w_pop[c]),
      .o_push_ok  (w_push_ok[c]),
      .o_head     (w_head[c]),
      .o_tail     (w_tail[c]),
      .o_count    (w_count[c]),
      .o_nonempty (w_nonempty[c])
    );

    simple_dual_port_mem #(
      .DW (DATA_WIDTH),
      .AW (AW)
    ) u_mem (
      .clk     (clk),
      .i_we    (w_push_ok[c]),
      .i_waddr (w_tail[c]),
      .i_wdata (in_data),
      .i_re    (w_pop[c]),
      .i_raddr (w_head[c]),
      .o_rdata (w_rdata[c])
    );

    assign occupancy[c*CNTW +: CNTW] = w_count[c];
  end

  // Strict-priority pick over non-empty classes.
  always_comb begin
    w_mask = '0;
    for (int c = 0; c < NUM_CLASS; c++) w_mask[c] = w_nonempty[c];
  end

  assign w_pick_idx = prio_pick(w_mask);

  always_comb begin
    w_pick = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (w_pick_idx == class_idx_t'(c)) w_pick = CW'(c);
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; a pop in HOLD fetches straight away to keep a 1-cycle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_load      = 1'b0;
    w_pop_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_nonempty) begin
          w_fetch     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_load      = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_pop_out = 1'b1;
          if (|w_nonempty) begin
            w_fetch     = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output stage: latch RAM data in FETCH, hold until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_class <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_class   <= '0;
    end else begin
      if (w_fetch) r_fetch_class <= w_pick;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rdata[r_fetch_class];
        r_out_class <= r_fetch_class;
      end else if (w_pop_out) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Saturating drop counter.
  assign w_drop = in_en && !(|w_push_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
  end

`ifdef EGRESS_WATERMARK_EN
  logic [NUM_CLASS-1:0] r_almost_full;

  // Watermark flags trail the count change by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_almost_full <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        r_almost_full[c] <= (w_count[c] >= CNTW'(HI_WM));
      end
    end
  end

  assign almost_full = r_almost_full;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_class = r_out_class;
  assign drop_cnt  = r_drop_cnt;

endmodule
